// File: rtl/gf163_result_ser_if.sv
// Handshake bundle for the GF(2^163) result serializer: product input stream,
// digit output stream, frame abort and busy status.
interface gf163_result_ser_if #(
  parameter int M = 163,
  parameter int D = 8
);
  logic         res_valid;
  logic         res_ready;
  logic [M-1:0] res_data;
  logic         flush;
  logic [D-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;
  logic         busy;

  modport slave (
    input  res_valid, res_data, flush, dout_ready,
    output res_ready, dout, dout_valid, dout_last, busy
  );

  modport master (
    output res_valid, res_data, flush, dout_ready,
    input  res_ready, dout, dout_valid, dout_last, busy
  );
endinterface

// File: rtl/gf163_result_ser.sv
// Emits one GF(2^163) product as 21 LSD-first digits; digit 0 appears the cycle after acceptance.
// Stalls on dout_ready hold all outputs; one IDLE bubble separates frames; flush aborts a frame.
module gf163_result_ser #(
  parameter int M = 163,
  parameter int D = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  gf163_result_ser_if.slave    bus
);
  localparam int NDIG = (M + D - 1) / D;
  localparam int CW   = $clog2(NDIG);
  localparam int W    = NDIG * D;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state;
  logic [W-1:0]  sreg;
  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.res_valid) begin
            sreg  <= {{(W - M){1'b0}}, bus.res_data};
            cnt   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          // flush wins over a same-cycle handshake; clearing sreg keeps dout at 0 in IDLE
          if (bus.flush) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
          end else if (bus.dout_ready) begin
            sreg <= sreg >> D;
            if (last) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // sreg is all-zero whenever the FSM sits in IDLE, so dout needs no gating
  assign bus.res_ready  = (state == IDLE);
  assign bus.busy       = (state == SEND);
  assign bus.dout_valid = (state == SEND);
  assign bus.dout       = sreg[D-1:0];
  assign bus.dout_last  = (state == SEND) && last;
endmodule

// File: tb/tb_gf163_result_ser.sv
// Bench for gf163_result_ser: vector table, hand-written corner sequences and
// random frames against a digit-extraction reference model.
module tb_gf163_result_ser;
  logic clk;
  logic rstn;
  int   n_pass;
  int   n_total;

  gf163_result_ser_if #(.M(163), .D(8)) bus ();

  gf163_result_ser #(.M(163), .D(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [162:0] data;
    int           mode;        // 0: always ready, 1: stall 3 at digit 5 then toggle
    int           exp_first;
    int           exp_last;
    int           exp_cycles;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] model_digit(input logic [162:0] d, input int k);
    logic [167:0] x;
    x = {5'b0, d};
    x = x >> (8 * k);
    return x[7:0];
  endfunction

  function automatic logic [162:0] ord_data();
    logic [162:0] d;
    d = '0;
    for (int k = 0; k < 20; k++) d[8*k +: 8] = 8'(k);
    d[162:160] = 3'b100;
    return d;
  endfunction

  function automatic logic [162:0] rnd_data();
    return 163'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  // Called at a negedge with res_ready expected high; returns at the negedge
  // where the accepted product's digit 0 should be presented.
  task automatic accept(input logic [162:0] data);
    int w;
    w = 0;
    while (bus.res_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", bus.res_ready, 1);
    bus.res_valid = 1'b1;
    bus.res_data  = data;
    @(negedge clk);
    bus.res_valid = 1'b0;
  endtask

  // Consumes a frame digit by digit. stop_at >= 0 returns with that digit
  // presented and not consumed. exp_cycles < 0 means 21 + observed stalls.
  task automatic stream(input logic [162:0] data, input int mode, input int stop_at,
                        input int exp_first, input int exp_last, input int exp_cycles);
    int   k, cyc, stalls, stall_left;
    bit   tog;
    logic r;
    k = 0; cyc = 0; stalls = 0; stall_left = 3; tog = 1'b1;
    while (k < 21) begin
      if (cyc > 400) begin
        n_total++;
        $display("FAIL stream_timeout: got %0d digits, expected 21", k);
        bus.dout_ready = 1'b0;
        return;
      end
      chk("dout_valid", bus.dout_valid, 1);
      chk("busy", bus.busy, 1);
      chk("res_ready_send", bus.res_ready, 0);
      chk($sformatf("dout[%0d]", k), bus.dout, model_digit(data, k));
      chk($sformatf("dout_last[%0d]", k), bus.dout_last, (k == 20));
      if (k == 0 && exp_first >= 0 && cyc == 0) chk("table_first", bus.dout, exp_first);
      if (k == 20 && exp_last >= 0) chk("table_last", bus.dout, exp_last);
      if (k == stop_at) begin
        bus.dout_ready = 1'b0;
        return;
      end
      case (mode)
        0: r = 1'b1;
        1: begin
          if (k == 5 && stall_left > 0) begin
            r = 1'b0;
            stall_left--;
          end else if (k >= 5) begin
            r = tog;
            tog = !tog;
          end else begin
            r = 1'b1;
          end
        end
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      bus.dout_ready = r;
      if (!r) stalls++;
      @(negedge clk);
      cyc++;
      if (r) k++;
    end
    bus.dout_ready = 1'b0;
    chk("frame_cycles", cyc, (exp_cycles >= 0) ? exp_cycles : 21 + stalls);
    chk("bubble_res_ready", bus.res_ready, 1);
    chk("bubble_dout_valid", bus.dout_valid, 0);
    chk("bubble_busy", bus.busy, 0);
  endtask

  vec_t tbl [3];

  initial begin
    logic [162:0] a, b;
    n_pass = 0;
    n_total = 0;
    bus.res_valid  = 1'b0;
    bus.res_data   = '0;
    bus.flush      = 1'b0;
    bus.dout_ready = 1'b0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    chk("rst_res_ready", bus.res_ready, 1);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_dout_last", bus.dout_last, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    tbl[0] = '{ord_data(), 0, 8'h00, 8'h04, 21};
    tbl[1] = '{{163{1'b1}}, 0, 8'hFF, 8'h07, 21};
    tbl[2] = '{ord_data(), 1, 8'h00, 8'h04, 39};
    for (int i = 0; i < 3; i++) begin
      accept(tbl[i].data);
      stream(tbl[i].data, tbl[i].mode, -1, tbl[i].exp_first, tbl[i].exp_last, tbl[i].exp_cycles);
    end

    // back-to-back: res_valid stays high across the first frame
    a = rnd_data();
    b = rnd_data();
    bus.res_valid = 1'b1;
    bus.res_data  = a;
    @(negedge clk);
    bus.res_data = b;
    stream(a, 0, -1, -1, -1, 21);
    @(negedge clk);
    bus.res_valid = 1'b0;
    stream(b, 0, -1, -1, -1, 21);

    // flush while digit 7 is presented with dout_ready high
    a = ord_data();
    accept(a);
    stream(a, 0, 7, -1, -1, -1);
    bus.flush      = 1'b1;
    bus.dout_ready = 1'b1;
    @(negedge clk);
    bus.flush      = 1'b0;
    bus.dout_ready = 1'b0;
    chk("flush_dout_valid", bus.dout_valid, 0);
    chk("flush_res_ready", bus.res_ready, 1);
    chk("flush_dout", bus.dout, 0);
    b = rnd_data();
    accept(b);
    stream(b, 0, -1, -1, -1, 21);

    // asynchronous reset between edges at digit 10
    a = rnd_data();
    accept(a);
    stream(a, 0, 10, -1, -1, -1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_dout_valid", bus.dout_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_dout", bus.dout, 0);
    chk("arst_res_ready", bus.res_ready, 1);
    #1 rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_quiet", bus.dout_valid, 0);
    end
    b = rnd_data();
    accept(b);
    stream(b, 0, -1, -1, -1, 21);

    // random products with random back-pressure
    for (int i = 0; i < 12; i++) begin
      a = rnd_data();
      accept(a);
      stream(a, 2, -1, -1, -1, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
